vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart to the sync generators. It watches a 640x480 sync stream (`hsync_n`, `vsync_n`) on the `CLK_40` domain, qualified by the pixel enable, and recovers the pixel position. It also checks line and frame lengths against the configured timing and reports lock status and data-enable. It sits on the loopback/self-check path between the sync generators and the pixel/debug logic.

## Interface
Parameters:
- `H_AREA`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_AREA`, 480, active lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `SYNC_POL`, 1, level on `hsync_n`/`vsync_n` that means "inside pulse"
- `LOCK_FRAMES`, 2, consecutive clean frames required to lock
- Derived values, fixed by the above:
  - `H_TOTAL` = sum of the H values = 800
  - `V_TOTAL` = sum of the V values = 525
  - `XW` = clog2(`H_TOTAL`)
  - `YW` = clog2(`V_TOTAL`)

Ports:
- `CLK_40`, in, 1: system clock
- `reset`, in, 1: asynchronous, active-low (0 = in reset)
- `pixel_clk`, in, 1: one-cycle enable. All sampling and counting happens only on cycles where it is 1.
- `hsync_n`, in, 1: horizontal sync from the generator
- `vsync_n`, in, 1: vertical sync from the generator
- `x_pos`, out, `XW`: recovered column
- `y_pos`, out, `YW`: recovered row
- `de`, out, 1: high when locked and (`x_pos` < `H_AREA`) and (`y_pos` < `V_AREA`)
- `frame_start`, out, 1: one-`CLK_40` pulse when `x_pos` = 0 and `y_pos` = 0 while locked
- `locked`, out, 1: FSM is in LOCKED
- `h_err`, out, 1: one-cycle pulse on a line-length mismatch
- `v_err`, out, 1: one-cycle pulse on a frame-length mismatch
- `err_count`, out, 8: saturating error count (see Configuration)

## Operation
- On each enable, register `hs = (hsync_n == SYNC_POL)` and `vs = (vsync_n == SYNC_POL)` plus their previous values. A leading edge is a 0→1 transition between consecutive enables.
- hsync leading edge:
  - `x_pos` <= `H_AREA+H_FP` (656).
  - Check the enable count since the previous leading edge: if it is ≠ `H_TOTAL`, pulse `h_err`.
  - Restart the line-length counter at 1.
- Otherwise `x_pos` increments and wraps from `H_TOTAL-1` to 0. On that wrap, `y_pos` increments and wraps from `V_TOTAL-1` to 0.
- vsync leading edge:
  - `y_pos` <= `V_AREA+V_FP` (490).
  - Check the line count since the previous vsync edge: if it is ≠ `V_TOTAL`, pulse `v_err`.
- If both leading edges fall on the same enable, apply both loads.
- Length counters saturate at all-ones. A saturated count is a mismatch.
- The first edge after reset or after SEARCH is entered has no previous reference. It produces no error.
- Lock FSM states:
  - SEARCH: wait for a vsync leading edge, then go to TRACK with the clean-frame counter = 0.
  - TRACK:
    - `h_err` or `v_err` → SEARCH.
    - Each clean vsync edge increments the clean-frame counter.
    - When the counter reaches `LOCK_FRAMES` → LOCKED.
  - LOCKED: any `h_err` or `v_err` → SEARCH, with `locked` low on the following cycle.
- `de` and `frame_start` are forced 0 when not LOCKED.

## Timing
- All outputs are registered.
- An enable at cycle N updates `x_pos`, `y_pos`, `de`, `h_err`, `v_err` and `frame_start` at N+1.
- The first enable with the pulse active is the edge sample, so `x_pos` = 656 is visible one cycle after it.
- Outputs hold between enables. Pulse outputs are high for exactly one `CLK_40` cycle.
- Reset values: `x_pos` 0, `y_pos` 0, `de` 0, `frame_start` 0, `locked` 0, `h_err` 0, `v_err` 0, `err_count` 0.
- Reset also clears the FSM to SEARCH, clears the sync history to inactive, and clears all counters.
- Reset asserted mid-frame clears everything immediately. After release, lock requires a fresh vsync edge plus `LOCK_FRAMES` clean frames.
- `pixel_clk` is ignored while reset is asserted.

## Configuration
- `VGA_DEC_STATS_EN` defined:
  - `err_count` increments on every cycle where `h_err` or `v_err` is high, by 1 only even if both fire.
  - It saturates at 255 and clears only on reset.
- `VGA_DEC_STATS_EN` not defined:
  - The counter logic is absent.
  - `err_count` is driven constant 0.

## Test plan
- Nominal stream (800x525, `pixel_clk` every 4th `CLK_40`) → `locked` rises after the 2nd clean vsync edge following the first. `de` high exactly 640x480 enables per frame. `h_err`/`v_err` never pulse.
- Locked, then one line shortened to 799 enables → `h_err` pulses once, `locked` falls the next cycle, `err_count` = 1. The decoder relocks after 3 vsync edges.
- Locked, then one frame of 526 lines → `v_err` pulses at that vsync edge, FSM returns to SEARCH, `de` goes 0.
- hsync and vsync leading edges on the same enable → `x_pos` = 656 and `y_pos` = 490 on the next cycle.
- Reset pulsed low mid-line while locked → all outputs 0 asynchronously. No `h_err` on the first hsync edge after release.
- With `VGA_DEC_STATS_EN`, 300 forced line errors → `err_count` saturates at 255.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive-side sync decoder. Watches an hsync/vsync stream on CLK_40, qualified
// by the pixel_clk enable, recovers the pixel position (x_pos/y_pos), checks line
// and frame lengths against the configured timing and tracks lock.
// Optional feature macro: VGA_DEC_STATS_EN -- enables the saturating error
// counter on err_count; without it err_count is tied to 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// SEARCH | no timing reference; waiting for a vsync leading edge
// TRACK  | reference taken; counting clean vsync edges toward lock
// LOCKED | LOCK_FRAMES clean frames seen; de and frame_start enabled

module vga_sync_decoder #(
    parameter int H_AREA      = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_AREA      = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 1,
    parameter int LOCK_FRAMES = 2,
    localparam int H_TOTAL    = H_AREA + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_AREA + V_FP + V_SYNC + V_BP,
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL)
) (
    input  logic          CLK_40,
    input  logic          reset,
    input  logic          pixel_clk,
    input  logic          hsync_n,
    input  logic          vsync_n,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          de,
    output logic          frame_start,
    output logic          locked,
    output logic          h_err,
    output logic          v_err,
    output logic [7:0]    err_count
);

    // Length counters get one extra bit so H_TOTAL/V_TOTAL always fit and the
    // saturated all-ones value can never alias a correct length.
    localparam int HCW = XW + 1;
    localparam int VCW = YW + 1;
    localparam int FW  = $clog2(LOCK_FRAMES + 1);

    localparam logic            ACT      = (SYNC_POL != 0);
    localparam logic [XW-1:0]   X_LOAD   = XW'(H_AREA + H_FP);
    localparam logic [XW-1:0]   X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]   Y_LOAD   = YW'(V_AREA + V_FP);
    localparam logic [YW-1:0]   Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0]   X_ACT    = XW'(H_AREA);
    localparam logic [YW-1:0]   Y_ACT    = YW'(V_AREA);
    localparam logic [HCW-1:0]  H_LEN    = HCW'(H_TOTAL);
    localparam logic [VCW-1:0]  V_LEN    = VCW'(V_TOTAL);
    localparam logic [HCW-1:0]  H_SAT    = '1;
    localparam logic [VCW-1:0]  V_SAT    = '1;
    localparam logic [FW-1:0]   FRM_LAST = FW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            hs_now;
    logic            vs_now;
    logic            hs_prev;
    logic            vs_prev;
    logic            hs_edge;
    logic            vs_edge;

    logic [HCW-1:0]  h_cnt;
    logic [VCW-1:0]  v_cnt;
    logic            h_ref;
    logic            v_ref;
    logic            h_mis;
    logic            v_mis;
    logic            v_evt;

    logic [XW-1:0]   x_nxt;
    logic [YW-1:0]   y_nxt;

    logic [FW-1:0]   frm_cnt;
    logic            lock_nxt;
    logic            frm_clr;
    logic            frm_inc;
    logic            ref_clr;

    // Sync levels normalised to "inside pulse"; leading edges only count on enables.
    assign hs_now  = (hsync_n == ACT);
    assign vs_now  = (vsync_n == ACT);
    assign hs_edge = pixel_clk && hs_now && !hs_prev;
    assign vs_edge = pixel_clk && vs_now && !vs_prev;

    // A length is only judged when an earlier edge gave a reference point.
    assign h_mis = hs_edge && h_ref && (h_cnt != H_LEN);
    assign v_mis = vs_edge && v_ref && (v_cnt != V_LEN);

    // Sync history, sampled on each enable.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else if (pixel_clk) begin
            hs_prev <= hs_now;
            vs_prev <= vs_now;
        end
    end

    // Enables since the last hsync edge; restarts at 1 so a correct line reads H_TOTAL.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
        end else if (pixel_clk) begin
            if (hs_edge)
                h_cnt <= HCW'(1);
            else if (h_cnt != H_SAT)
                h_cnt <= h_cnt + HCW'(1);
        end
    end

    // hsync edges since the last vsync edge; an hsync edge on the vsync enable
    // belongs to the new frame.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            v_cnt <= '0;
        end else if (vs_edge) begin
            v_cnt <= hs_edge ? VCW'(1) : '0;
        end else if (hs_edge && (v_cnt != V_SAT)) begin
            v_cnt <= v_cnt + VCW'(1);
        end
    end

    // Reference flags: set by the first edge, dropped whenever SEARCH is re-entered.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            h_ref <= 1'b0;
            v_ref <= 1'b0;
        end else if (ref_clr) begin
            h_ref <= 1'b0;
            v_ref <= 1'b0;
        end else begin
            if (hs_edge) h_ref <= 1'b1;
            if (vs_edge) v_ref <= 1'b1;
        end
    end

    // Next position: sync edges load the porch position, otherwise free-run and wrap.
    always_comb begin
        x_nxt = x_pos;
        y_nxt = y_pos;
        if (pixel_clk) begin
            if (hs_edge) begin
                x_nxt = X_LOAD;
            end else if (x_pos == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y_pos == Y_LAST) ? '0 : y_pos + YW'(1);
            end else begin
                x_nxt = x_pos + XW'(1);
            end
            if (vs_edge)
                y_nxt = Y_LOAD;
        end
    end

    // Registered position, error pulses and the vsync event fed to the FSM.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            x_pos <= '0;
            y_pos <= '0;
            h_err <= 1'b0;
            v_err <= 1'b0;
            v_evt <= 1'b0;
        end else begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
            h_err <= h_mis;
            v_err <= v_mis;
            v_evt <= vs_edge;
        end
    end

    // de/frame_start follow the next state so they drop together with locked.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            de          <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            de          <= lock_nxt && (x_nxt < X_ACT) && (y_nxt < Y_ACT);
            frame_start <= lock_nxt && pixel_clk && (x_nxt == '0) && (y_nxt == '0);
            locked      <= lock_nxt;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    // Lock FSM next state; reacts to the registered error pulses and vsync event.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (v_evt)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (h_err || v_err)
                    state_nxt = SEARCH;
                else if (v_evt && (frm_cnt >= FRM_LAST))
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (h_err || v_err)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Lock FSM outputs.
    always_comb begin
        lock_nxt = (state_nxt == LOCKED);
        frm_clr  = (state == SEARCH);
        frm_inc  = (state == TRACK) && v_evt && !h_err && !v_err;
        ref_clr  = (state != SEARCH) && (state_nxt == SEARCH);
    end

    // Clean-frame counter used while tracking.
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset)
            frm_cnt <= '0;
        else if (frm_clr)
            frm_cnt <= '0;
        else if (frm_inc)
            frm_cnt <= frm_cnt + FW'(1);
    end

`ifdef VGA_DEC_STATS_EN
    // Saturating count of cycles carrying an error pulse (both at once count once).
    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset)
            err_count <= 8'd0;
        else if ((h_err || v_err) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Directed bench: a small-timing instance (16x11 raster) driven by a behavioural
// sync generator, plus a default-parameter instance for the coincident-edge load.

module tb_vga_sync_decoder;

    // small raster: H 8+2+3+3 = 16, V 6+1+2+2 = 11
    localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int HS0 = HA + HF, HS1 = HA + HF + HSW;
    localparam int VS0 = VA + VF, VS1 = VA + VF + VSW;

`ifdef VGA_DEC_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic       clk, rst, pclk, hs, vs;
    logic [3:0] x, y;
    logic       de, fs, lk, he, ve;
    logic [7:0] ec;

    logic       pclk_f, hs_f, vs_f;
    logic [9:0] x_f, y_f;
    logic       de_f, fs_f, lk_f, he_f, ve_f;
    logic [7:0] ec_f;

    int n_chk = 0;
    int n_fail = 0;

    int gx, gy, vlen, short_gy;
    bit short_all, chk_pos, chk_fall;
    int de_cnt, fs_cnt, herr_cnt, verr_cnt, pos_bad;

    vga_sync_decoder #(
        .H_AREA(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_AREA(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1), .LOCK_FRAMES(2)
    ) dut (
        .CLK_40(clk), .reset(rst), .pixel_clk(pclk),
        .hsync_n(hs), .vsync_n(vs),
        .x_pos(x), .y_pos(y), .de(de), .frame_start(fs), .locked(lk),
        .h_err(he), .v_err(ve), .err_count(ec)
    );

    vga_sync_decoder dut_full (
        .CLK_40(clk), .reset(rst), .pixel_clk(pclk_f),
        .hsync_n(hs_f), .vsync_n(vs_f),
        .x_pos(x_f), .y_pos(y_f), .de(de_f), .frame_start(fs_f), .locked(lk_f),
        .h_err(he_f), .v_err(ve_f), .err_count(ec_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One generator enable: present sync for (gx,gy), sample outputs, advance.
    task automatic pix();
        int  sx, sy, hl;
        logic e;
        hs   = (gx >= HS0 && gx < HS1);
        vs   = (gy >= VS0 && gy < VS1);
        pclk = 1'b1;
        @(posedge clk); #1;
        pclk = 1'b0;
        sx = gx;
        sy = gy;
        de_cnt   += int'(de);
        fs_cnt   += int'(fs);
        herr_cnt += int'(he);
        verr_cnt += int'(ve);
        if (chk_pos && (int'(x) != sx || int'(y) != sy)) pos_bad++;
        e = he | ve;
        if (chk_fall && e) check("locked_at_err", int'(lk), 1);
        @(posedge clk); #1;
        if (chk_fall && e) begin
            check("locked_fall", int'(lk), 0);
            check("err_pulse_1cyc", int'(he | ve), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        hl = (short_all || gy == short_gy) ? HT - 1 : HT;
        if (gx + 1 >= hl) begin
            gx = 0;
            gy = (gy + 1 >= vlen) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic run_frame(input int vl, input int sgy);
        vlen = vl;
        short_gy = sgy;
        de_cnt = 0; fs_cnt = 0; herr_cnt = 0; verr_cnt = 0; pos_bad = 0;
        pix();
        while (!(gx == 0 && gy == 0)) pix();
    endtask

    initial begin
        rst = 1'b0; pclk = 1'b0; hs = 1'b0; vs = 1'b0;
        pclk_f = 1'b0; hs_f = 1'b0; vs_f = 1'b0;
        gx = 0; gy = 0; vlen = 11; short_gy = -1;
        short_all = 0; chk_pos = 0; chk_fall = 0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_de", int'(de), 0);
        check("rst_fs", int'(fs), 0);
        check("rst_locked", int'(lk), 0);
        check("rst_herr", int'(he), 0);
        check("rst_verr", int'(ve), 0);
        check("rst_errcnt", int'(ec), 0);
        check("rst_full_x", int'(x_f), 0);
        check("rst_full_y", int'(y_f), 0);
        check("rst_full_misc", int'({de_f, fs_f, lk_f, he_f, ve_f}), 0);
        check("rst_full_errcnt", int'(ec_f), 0);

        #3 rst = 1'b1;
        @(posedge clk); #1;

        // default timing: free-run one enable, then coincident hsync+vsync edges
        pclk_f = 1'b1;
        @(posedge clk); #1;
        pclk_f = 1'b0;
        check("full_freerun_x", int'(x_f), 1);
        check("full_freerun_y", int'(y_f), 0);
        hs_f = 1'b1; vs_f = 1'b1; pclk_f = 1'b1;
        @(posedge clk); #1;
        pclk_f = 1'b0;
        check("both_edges_x", int'(x_f), 656);
        check("both_edges_y", int'(y_f), 490);
        check("both_edges_noerr", int'({he_f, ve_f}), 0);
        pclk_f = 1'b1;
        @(posedge clk); #1;
        pclk_f = 1'b0;
        check("in_pulse_x", int'(x_f), 657);
        check("in_pulse_y", int'(y_f), 490);

        // nominal stream: lock after the third vsync edge
        run_frame(11, -1);
        check("f1_locked", int'(lk), 0);
        check("f1_errs", herr_cnt + verr_cnt, 0);
        run_frame(11, -1);
        check("f2_locked", int'(lk), 0);
        check("f2_errs", herr_cnt + verr_cnt, 0);
        run_frame(11, -1);
        check("f3_locked", int'(lk), 1);
        check("f3_de", de_cnt, 0);
        chk_pos = 1;
        run_frame(11, -1);
        chk_pos = 0;
        check("f4_de", de_cnt, HA * VA);
        check("f4_fs", fs_cnt, 1);
        check("f4_pos", pos_bad, 0);
        check("f4_errs", herr_cnt + verr_cnt, 0);

        // one short line
        chk_fall = 1;
        run_frame(11, 2);
        chk_fall = 0;
        check("f5_herr", herr_cnt, 1);
        check("f5_verr", verr_cnt, 0);
        check("f5_locked", int'(lk), 0);
        check("f5_errcnt", int'(ec), STATS);
        run_frame(11, -1);
        check("f6_locked", int'(lk), 0);
        check("f6_herr", herr_cnt, 0);
        run_frame(11, -1);
        check("f7_relocked", int'(lk), 1);

        // one 12-line frame
        chk_pos = 1;
        run_frame(11, -1);
        chk_pos = 0;
        check("f8_de", de_cnt, HA * VA);
        check("f8_pos", pos_bad, 0);
        run_frame(12, -1);
        check("f9_de", de_cnt, HA * VA + HA);
        check("f9_fs", fs_cnt, 2);
        check("f9_verr", verr_cnt, 0);
        chk_fall = 1;
        run_frame(11, -1);
        chk_fall = 0;
        check("f10_verr", verr_cnt, 1);
        check("f10_herr", herr_cnt, 0);
        check("f10_de", de_cnt, HA * (VA - 1));
        check("f10_fs", fs_cnt, 0);
        check("f10_locked", int'(lk), 0);
        check("f10_errcnt", int'(ec), 2 * STATS);
        run_frame(11, -1);
        check("f11_de", de_cnt, 0);
        check("f11_locked", int'(lk), 0);
        run_frame(11, -1);
        check("f12_locked", int'(lk), 0);
        run_frame(11, -1);
        check("f13_locked", int'(lk), 1);

        // asynchronous reset mid-line while locked
        vlen = 11;
        short_gy = -1;
        while (!(gy == 2 && gx == 4)) pix();
        check("pre_rst_de", int'(de), 1);
        check("pre_rst_x", int'(x), 3);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_de", int'(de), 0);
        check("mid_rst_locked", int'(lk), 0);
        check("mid_rst_pulses", int'({fs, he, ve}), 0);
        check("mid_rst_errcnt", int'(ec), 0);
        check("mid_rst_full_x", int'(x_f), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        run_frame(11, -1);
        check("post_rst_herr", herr_cnt, 0);
        check("post_rst_verr", verr_cnt, 0);
        check("post_rst_locked", int'(lk), 0);
        run_frame(11, -1);
        check("f15_locked", int'(lk), 0);
        run_frame(11, -1);
        check("f16_locked", int'(lk), 1);

`ifdef VGA_DEC_STATS_EN
        // continuous short lines drive the error counter into saturation
        short_all = 1;
        for (int i = 0; i < 320 * (HT - 1); i++) pix();
        short_all = 0;
        check("errcnt_sat", int'(ec), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
